// File: rtl/store_align_buf.sv
// Store packer and in-order store buffer between the MEM stage and data memory.
// Narrow stores are replicated across the word and tagged with byte enables.
module store_align_buf #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [1:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_ready,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  output logic             align_err,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] buf_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [29:0]      addr_q  [DEPTH];
  logic [29:0]      addr_d  [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [31:0]      wdata_d [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [3:0]       be_d    [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             align_err_q, align_err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic        legal;
  logic [31:0] pk_wdata;
  logic [3:0]  pk_be;
  logic        push;
  logic        rej;
  logic        pop;

  always_comb begin
    legal    = 1'b0;
    pk_wdata = 32'h0;
    pk_be    = 4'b0000;
    unique case (st_op)
      2'd0: begin
        pk_wdata = st_data;
        pk_be    = 4'b1111;
        legal    = (st_addr[1:0] == 2'b00);
      end
      2'd1: begin
        pk_wdata = {2{st_data[15:0]}};
        pk_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        legal    = !st_addr[0];
      end
      2'd2: begin
        pk_wdata = {4{st_data[7:0]}};
        pk_be    = 4'b0001 << st_addr[1:0];
        legal    = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Ready depends on occupancy alone; no retire-to-accept bypass.
  assign st_ready = (count_q < DEPTH_C);
  assign mem_req  = (count_q != '0);
  assign push     = st_valid & st_ready & legal;
  assign rej      = st_valid & st_ready & !legal;
  assign pop      = mem_req & mem_ack;

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    align_err_d = rej;
    err_addr_d  = rej ? st_addr : err_addr_q;
    if (push) begin
      addr_d[wr_ptr_q]  = st_addr[31:2];
      wdata_d[wr_ptr_q] = pk_wdata;
      be_d[wr_ptr_q]    = pk_be;
      wr_ptr_d          = wr_ptr_q + PONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PONE;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      align_err_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      align_err_q <= align_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Drive zeros when empty so stale entries never reach the bus.
  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    if (mem_req) begin
      mem_addr  = {addr_q[rd_ptr_q], 2'b00};
      mem_wdata = wdata_q[rd_ptr_q];
      mem_be    = be_q[rd_ptr_q];
    end
  end

  assign align_err = align_err_q;
  assign err_addr  = err_addr_q;
  assign buf_count = count_q;

endmodule
